// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage core: per-register enables,
// bubble insertion, MDU start pulse and a saturating stall-cycle counter.
module pipeline_stall_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_use_stall_i,
    input  logic             branch_taken_ex_i,
    input  logic             mdu_op_ex_i,
    input  logic             mdu_done_i,
    output logic             mdu_start_o,
    input  logic             dmem_req_mem_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             id_ex_en_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_flush_o,
    output logic             mem_wb_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MDU_WAIT = 2'b01,
        MEM_WAIT = 2'b10
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_eval;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!pc_en_o && cnt_q != {CNT_W{1'b1}})
                cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = RUN;
        run_eval       = 1'b0;
        pc_en_o        = 1'b1;
        if_id_en_o     = 1'b1;
        id_ex_en_o     = 1'b1;
        ex_mem_en_o    = 1'b1;
        mem_wb_en_o    = 1'b1;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        mem_wb_flush_o = 1'b0;
        mdu_start_o    = 1'b0;

        case (state_q)
            MDU_WAIT: begin
                if (!mdu_done_i) begin
                    state_d        = MDU_WAIT;
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_en_o    = 1'b0;
                    ex_mem_flush_o = 1'b1;
                end else if (load_use_stall_i) begin
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!dmem_ready_i) begin
                    state_d        = MEM_WAIT;
                    pc_en_o        = 1'b0;
                    if_id_en_o     = 1'b0;
                    id_ex_en_o     = 1'b0;
                    ex_mem_en_o    = 1'b0;
                    mem_wb_en_o    = 1'b0;
                    mem_wb_flush_o = 1'b1;
                end else begin
                    run_eval = 1'b1;
                end
            end
            default: run_eval = 1'b1;
        endcase

        // A completing memory access falls through to the normal RUN rules.
        if (run_eval) begin
            if (dmem_req_mem_i && !dmem_ready_i) begin
                state_d        = MEM_WAIT;
                pc_en_o        = 1'b0;
                if_id_en_o     = 1'b0;
                id_ex_en_o     = 1'b0;
                ex_mem_en_o    = 1'b0;
                mem_wb_en_o    = 1'b0;
                mem_wb_flush_o = 1'b1;
            end else if (mdu_op_ex_i) begin
                state_d        = MDU_WAIT;
                mdu_start_o    = 1'b1;
                pc_en_o        = 1'b0;
                if_id_en_o     = 1'b0;
                id_ex_en_o     = 1'b0;
                ex_mem_en_o    = 1'b0;
                ex_mem_flush_o = 1'b1;
            end else if (branch_taken_ex_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
            end else if (load_use_stall_i) begin
                pc_en_o       = 1'b0;
                if_id_en_o    = 1'b0;
                id_ex_flush_o = 1'b1;
            end
        end

        if (rst_i) begin
            state_d        = RUN;
            pc_en_o        = 1'b0;
            if_id_en_o     = 1'b0;
            id_ex_en_o     = 1'b0;
            ex_mem_en_o    = 1'b0;
            mem_wb_en_o    = 1'b0;
            if_id_flush_o  = 1'b0;
            id_ex_flush_o  = 1'b0;
            ex_mem_flush_o = 1'b0;
            mem_wb_flush_o = 1'b0;
            mdu_start_o    = 1'b0;
        end
    end

    assign state_o        = state_q;
    assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller: an action-level model
// predicts each cycle's outputs; a negedge monitor compares them.
module tb_pipeline_stall_controller;

    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1, lu = 1'b0, br = 1'b0, op = 1'b0;
    logic done = 1'b0, req = 1'b0, rdy = 1'b0;
    logic mdu_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl;
    logic [1:0] state;
    logic [CNT_W-1:0] cnt;

    pipeline_stall_controller #(.CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .load_use_stall_i(lu), .branch_taken_ex_i(br),
        .mdu_op_ex_i(op), .mdu_done_i(done), .mdu_start_o(mdu_start),
        .dmem_req_mem_i(req), .dmem_ready_i(rdy),
        .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en),
        .ex_mem_en_o(ex_mem_en), .mem_wb_en_o(mem_wb_en),
        .if_id_flush_o(if_id_fl), .id_ex_flush_o(id_ex_fl),
        .ex_mem_flush_o(ex_mem_fl), .mem_wb_flush_o(mem_wb_fl),
        .state_o(state), .stall_cycles_o(cnt)
    );

    typedef enum int {
        A_RESET, A_FREEZE, A_MDU_START, A_MDU_HOLD,
        A_BRANCH, A_LOADUSE, A_FLOW
    } act_t;

    // model: 0 = running, 1 = waiting on MDU, 2 = waiting on memory
    int mode = 0;
    int stalls = 0;
    logic [15:0] expq[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc_no = 0;

    function automatic act_t pick();
        if (rst) return A_RESET;
        if (mode == 1) return done ? (lu ? A_LOADUSE : A_FLOW) : A_MDU_HOLD;
        if (mode == 2 && !rdy) return A_FREEZE;
        if (req && !rdy) return A_FREEZE;
        if (op) return A_MDU_START;
        if (br) return A_BRANCH;
        if (lu) return A_LOADUSE;
        return A_FLOW;
    endfunction

    task automatic cyc(input logic r, l, b, o, d, q, y);
        act_t a;
        logic [4:0] en;
        logic [3:0] fl;
        logic st;
        @(posedge clk);
        #1;
        rst = r; lu = l; br = b; op = o; done = d; req = q; rdy = y;
        a = pick();
        st = 1'b0;
        case (a)
            A_RESET:     begin en = 5'b00000; fl = 4'b0000; end
            A_FREEZE:    begin en = 5'b00000; fl = 4'b0001; end
            A_MDU_START: begin en = 5'b00001; fl = 4'b0010; st = 1'b1; end
            A_MDU_HOLD:  begin en = 5'b00001; fl = 4'b0010; end
            A_BRANCH:    begin en = 5'b11111; fl = 4'b1100; end
            A_LOADUSE:   begin en = 5'b00111; fl = 4'b0100; end
            default:     begin en = 5'b11111; fl = 4'b0000; end
        endcase
        expq.push_back({en, fl, st, mode[1:0], stalls[CNT_W-1:0]});
        if (a == A_MDU_START || a == A_MDU_HOLD) mode = 1;
        else if (a == A_FREEZE) mode = 2;
        else mode = 0;
        if (r) stalls = 0;
        else if (!en[4] && stalls < MAXC) stalls++;
    endtask

    always @(negedge clk) begin
        logic [15:0] e, got;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl,
                   mdu_start, state, cnt};
            n_checks++;
            cyc_no++;
            if (got === e) n_pass++;
            else $display("FAIL cycle%0d: got %h required %h", cyc_no, got, e);
        end
    end

    initial begin
        repeat (3) cyc(1, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        repeat (4) cyc(0, 0, 1, 1, 0, 1, 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0, 1, 1);
        repeat (2) cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 1, 0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        repeat (20) cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 49) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 0);
        end
        for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
        #1;
        if (expq.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, required 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage core. Merges the load-use stall request from the hazard detection unit, EX-stage taken branches, multi-cycle MDU operations and data-memory wait states. It drives one enable per pipeline register plus the bubble-insertion (flush) controls, and issues the MDU start pulse. A saturating counter accumulates front-end stall cycles for performance monitoring.

## Interface
Parameters
- CNT_W, 16, width of stall-cycle performance counter

Ports
- clk_i  in  1  core clock, all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- load_use_stall_i  in  1  load-use stall request from hazard detection unit
- branch_taken_ex_i  in  1  branch/jump in EX resolved taken
- mdu_op_ex_i  in  1  EX holds a valid MUL/DIV instruction
- mdu_done_i  in  1  single-cycle pulse, MDU result valid
- mdu_start_o  out  1  single-cycle MDU start pulse
- dmem_req_mem_i  in  1  MEM holds a valid load/store
- dmem_ready_i  in  1  data memory completes access this cycle
- pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o  out  1 each  pipeline register load enables
- if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o  out  1 each  load bubble into that register (wins over its enable)
- state_o  out  2  current FSM state (debug)
- stall_cycles_o  out  CNT_W  cycles with pc_en_o=0 since reset, saturating

## Operation
- FSM: RUN=2'b00, MDU_WAIT=2'b01, MEM_WAIT=2'b10; 2'b11 unreachable, decodes as RUN.
- Default output set ("flow"): all enables 1, all flushes 0, mdu_start_o 0.
- RUN, evaluated in priority order, first match wins:
  - dmem_req_mem_i & ~dmem_ready_i: all enables 0, mem_wb_flush_o=1; next MEM_WAIT.
  - mdu_op_ex_i: mdu_start_o=1; pc/if_id/id_ex/ex_mem enables 0, ex_mem_flush_o=1, mem_wb_en_o=1; next MDU_WAIT.
  - branch_taken_ex_i: flow + if_id_flush_o=1, id_ex_flush_o=1; stay RUN. Overrides load_use_stall_i.
  - load_use_stall_i: pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1, rest flow; stay RUN.
  - Otherwise flow.
- MDU_WAIT:
  - ~mdu_done_i: same outputs as MDU entry but mdu_start_o=0; stay.
  - mdu_done_i: ex_mem_en_o=1 (captures result), then load_use_stall_i applied as in RUN; mdu_start_o=0; next RUN.
  - dmem_* and branch_taken_ex_i ignored (MEM holds bubble, EX holds MDU op).
- MEM_WAIT:
  - ~dmem_ready_i: all enables 0, mem_wb_flush_o=1; stay.
  - dmem_ready_i: full RUN evaluation this cycle (may go to MDU_WAIT, flush, stall or flow).
- mdu_done_i in RUN or MEM_WAIT is ignored.
- Counter: +1 each cycle pc_en_o=0; holds at 2^CNT_W-1.

## Timing
- State and counter registered; all other outputs combinational from state and inputs, same cycle.
- Reset (rst_i=1 at edge): state RUN, stall_cycles_o 0. While rst_i high, outputs forced to enables 0, flushes 0, mdu_start_o 0. Reset mid-MDU_WAIT/MEM_WAIT returns to RUN; no start re-issued.
- mdu_start_o: exactly one cycle per MDU instruction, on the RUN→MDU_WAIT cycle. Earliest accepted mdu_done_i is the following cycle.
- MDU op of N wait cycles costs N+1 front-end stall cycles (entry + N, done cycle flows).
- Memory wait of K cycles freezes all stages K cycles; the ready cycle is normal.
- Load-use stall costs exactly one bubble per asserted cycle.

## Test plan
- Reset: hold rst_i 3 cycles with random inputs -> all enables 0, mdu_start_o 0, state_o 00, stall_cycles_o 0. Release -> flow outputs.
- Load-use: load_use_stall_i=1 for 1 cycle -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1. Next cycle flow, counter=1. With branch_taken_ex_i=1 in the same cycle -> branch flush only, pc_en_o=1.
- MDU: mdu_op_ex_i=1, mdu_done_i after 4 cycles -> mdu_start_o one pulse, state 01 for 4 cycles with ex_mem_flush_o=1, done cycle ex_mem_en_o=1, state 00, counter=5.
- Memory wait: dmem_req_mem_i=1, dmem_ready_i low 3 cycles -> all enables 0 and mem_wb_flush_o=1 for 3 cycles. Ready cycle with mdu_op_ex_i=1 -> mdu_start_o=1, next state 01.
- Reset mid-op: assert rst_i during MDU_WAIT, then send mdu_done_i after release -> state 00, no effect, no mdu_start_o.
- Saturation: CNT_W=4, hold load_use_stall_i 20 cycles -> stall_cycles_o stops at 15.
